// File: rtl/song_recorder.sv
// -----------------------------------------------------------------------------
// song_recorder
//   Write-side companion of song_reader. Samples the live key, times each held
//   note in beats and writes {note, duration} words into the song RAM. Every
//   recording session is closed with an all-zero end marker word.
//
//   RAM layout: wr_addr = {song, idx}. There are 2^IDX_W slots per song, and
//   the last slot is reserved for the end marker. When the last note slot is
//   used, the marker follows in the next cycle and the block goes FULL.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous, active-low reset
//   record     in   level, high while a record session is wanted
//   song       in   target song, sampled only on the record rising edge
//   key_valid  in   a key is held
//   key_note   in   note code of the held key (code 0 = rest)
//   beat       in   1-cycle beat pulse from beat_generator
//   wr_en      out  1-cycle RAM write strobe
//   wr_addr    out  {song_q, idx}
//   wr_data    out  {note, duration}; all zero = end marker
//   recording  out  high while tracking notes
//   full       out  song slots exhausted; held until record drops
//
// Configuration
//   SONG_RECORDER_SKIP_LEAD_REST_EN
//     defined   : after the record edge, timing waits for the first key, so
//                 leading silence is not recorded.
//     undefined : leading silence is recorded as rest entries {0, dur}.
// -----------------------------------------------------------------------------
module song_recorder #(
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6,
   parameter int IDX_W  = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      record,
   input  logic [1:0]                song,
   input  logic                      key_valid,
   input  logic [NOTE_W-1:0]         key_note,
   input  logic                      beat,
   output logic                      wr_en,
   output logic [2+IDX_W-1:0]        wr_addr,
   output logic [NOTE_W+DUR_W-1:0]   wr_data,
   output logic                      recording,
   output logic                      full
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TRACK,
      S_CLOSE,
      S_FULL
   } state_t;

   localparam logic [DUR_W-1:0] DUR_MAX       = '1;
   localparam logic [IDX_W-1:0] IDX_MARK      = '1;
   localparam logic [IDX_W-1:0] IDX_LAST_NOTE = IDX_MARK - 1'b1;

   state_t                state_q, state_d;
   logic [1:0]            song_q, song_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [DUR_W-1:0]      dur_q, dur_d;
   logic [NOTE_W-1:0]     cur_q, cur_d;
   logic                  record_q;
   // A marker still owed after a note write (double write spread over cycles).
   logic                  pend_q, pend_d;

   logic                  wr_en_d;
   logic [2+IDX_W-1:0]    wr_addr_d;
   logic [NOTE_W+DUR_W-1:0] wr_data_d;

   logic [NOTE_W-1:0]     live_note;
   logic                  beat_cnt;
   logic [DUR_W-1:0]      dur_eff;
   logic                  commit;

`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
   // High from the record edge until the first key: beats are not counted.
   logic                  lead_q, lead_d;
   assign beat_cnt = beat && !lead_q;
`else
   assign beat_cnt = beat;
`endif

   assign live_note = key_valid ? key_note : '0;
   // A beat arriving with a note change or record drop belongs to the old note.
   // dur_q never exceeds DUR_MAX-1 in TRACK, so this cannot overflow.
   assign dur_eff   = dur_q + DUR_W'(beat_cnt);

   // --------------------------------------------------------------------------
   // Next-state / write decision
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path through
      // the case can leave it unassigned and infer a latch.
      state_d   = state_q;
      song_d    = song_q;
      idx_d     = idx_q;
      dur_d     = dur_q;
      cur_d     = cur_q;
      pend_d    = pend_q;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      commit    = 1'b0;
`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
      lead_d    = lead_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (record && !record_q) begin
               song_d  = song;
               idx_d   = '0;
               dur_d   = '0;
               cur_d   = live_note;
               pend_d  = 1'b0;
               state_d = S_TRACK;
`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
               lead_d  = (live_note == '0);
`endif
            end
         end

         S_TRACK: begin
            if (!record) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {song_q, idx_q};
               if (dur_eff != '0) begin
                  // Note now, marker at idx+1 from CLOSE.
                  wr_data_d = {cur_q, dur_eff};
                  idx_d     = idx_q + 1'b1;
                  pend_d    = 1'b1;
               end else begin
                  wr_data_d = '0;
               end
               dur_d   = '0;
               state_d = S_CLOSE;
            end else if (live_note != cur_q) begin
               // dur_eff==0 is a sub-beat glitch: dropped without a write.
               commit = (dur_eff != '0);
               cur_d  = live_note;
               dur_d  = '0;
`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
               lead_d = 1'b0;
`endif
            end else if (beat_cnt) begin
               if (dur_eff == DUR_MAX) begin
                  // Long note: emit a full-length chunk and keep timing it.
                  commit = 1'b1;
                  dur_d  = '0;
               end else begin
                  dur_d  = dur_eff;
               end
            end

            if (commit) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {song_q, idx_q};
               wr_data_d = {cur_q, dur_eff};
               idx_d     = idx_q + 1'b1;
               if (idx_q == IDX_LAST_NOTE) begin
                  // Last note slot used: the reserved slot gets the marker next.
                  pend_d  = 1'b1;
                  state_d = S_FULL;
               end
            end
         end

         S_CLOSE: begin
            if (pend_q) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {song_q, idx_q};
               wr_data_d = '0;
               pend_d    = 1'b0;
            end
            state_d = S_IDLE;
         end

         S_FULL: begin
            if (pend_q) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {song_q, IDX_MARK};
               wr_data_d = '0;
               pend_d    = 1'b0;
            end else if (!record) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // State and registered outputs
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         song_q    <= '0;
         idx_q     <= '0;
         dur_q     <= '0;
         cur_q     <= '0;
         record_q  <= 1'b0;
         pend_q    <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         recording <= 1'b0;
         full      <= 1'b0;
`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
         lead_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         song_q    <= song_d;
         idx_q     <= idx_d;
         dur_q     <= dur_d;
         cur_q     <= cur_d;
         record_q  <= record;
         pend_q    <= pend_d;
         wr_en     <= wr_en_d;
         wr_addr   <= wr_addr_d;
         wr_data   <= wr_data_d;
         recording <= (state_d == S_TRACK);
         full      <= (state_d == S_FULL);
`ifdef SONG_RECORDER_SKIP_LEAD_REST_EN
         lead_q    <= lead_d;
`endif
      end
   end

endmodule

// File: tb/tb_song_recorder.sv
// -----------------------------------------------------------------------------
// tb_song_recorder
//   Self-checking bench for song_recorder. A per-cycle vector table covers the
//   basic record / note-change / glitch / pulse cases; hand-written sequences
//   cover long-note splitting, running out of slots, and reset mid-session.
// -----------------------------------------------------------------------------
module tb_song_recorder;

   logic        clk = 1'b0;
   logic        reset;
   logic        record;
   logic [1:0]  song;
   logic        key_valid;
   logic [5:0]  key_note;
   logic        beat;
   logic        wr_en;
   logic [6:0]  wr_addr;
   logic [11:0] wr_data;
   logic        recording;
   logic        full;

   song_recorder dut (
      .clk       (clk),
      .reset     (reset),
      .record    (record),
      .song      (song),
      .key_valid (key_valid),
      .key_note  (key_note),
      .beat      (beat),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .recording (recording),
      .full      (full)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic       rec;
      logic [1:0] sng;
      logic       kv;
      logic [5:0] kn;
      logic       bt;
      logic       e_wr;
      logic [6:0] e_addr;
      logic [11:0] e_data;
      logic       e_rec;
      logic       e_full;
   } vec_t;

   typedef struct packed {
      logic [6:0]  a;
      logic [11:0] d;
   } wr_t;

   wr_t  log_q[$];
   vec_t vecs[31];

   // Write log, sampled away from the active edge.
   always @(negedge clk) if (wr_en) log_q.push_back({wr_addr, wr_data});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   task automatic check_wr(input string name, input int k, input logic [6:0] ea, input logic [11:0] ed);
      wr_t w;
      w = (k < log_q.size()) ? log_q[k] : '1;
      check($sformatf("%s[%0d].addr", name, k), 32'(w.a), 32'(ea));
      check($sformatf("%s[%0d].data", name, k), 32'(w.d), 32'(ed));
   endtask

   // Drive inputs for the next edge, then return 1 time unit after it.
   task automatic cyc(input logic r, input logic [1:0] s, input logic kv, input logic [5:0] kn, input logic b);
      record = r; song = s; key_valid = kv; key_note = kn; beat = b;
      @(posedge clk); #1;
   endtask

   initial begin
      reset = 1'b0; record = 1'b0; song = 2'd0; key_valid = 1'b0; key_note = '0; beat = 1'b0;

      //               rec sng kv kn  bt | wr addr   data    rec full
      // 1: song 2, key 20 for 3 beats (song change mid-session ignored)
      vecs[0]  = '{1'b0, 2'd2, 1'b1, 6'd20, 1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 2'd2, 1'b1, 6'd20, 1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[2]  = '{1'b1, 2'd2, 1'b1, 6'd20, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 2'd0, 1'b1, 6'd20, 1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 2'd0, 1'b1, 6'd20, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 2'd0, 1'b1, 6'd20, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 2'd0, 1'b0, 6'd0,  1'b0, 1'b1, 7'h40, 12'h503, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b1, 7'h41, 12'h000, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};
      // 4: note change with beat at dur=2 -> {12,3}; then drop with dur=1
      vecs[9]  = '{1'b1, 2'd1, 1'b1, 6'd12, 1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 2'd1, 1'b1, 6'd12, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 2'd3, 1'b1, 6'd12, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[12] = '{1'b1, 2'd3, 1'b1, 6'd33, 1'b1, 1'b1, 7'h20, 12'h303, 1'b1, 1'b0};
      vecs[13] = '{1'b1, 2'd3, 1'b1, 6'd33, 1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[14] = '{1'b0, 2'd3, 1'b1, 6'd33, 1'b0, 1'b1, 7'h21, 12'h841, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 2'd3, 1'b1, 6'd33, 1'b0, 1'b1, 7'h22, 12'h000, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};
      // 3: glitch 5->7 inside one beat, 7 then timed for 2 beats
      vecs[17] = '{1'b1, 2'd0, 1'b1, 6'd5,  1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[18] = '{1'b1, 2'd0, 1'b1, 6'd7,  1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[19] = '{1'b1, 2'd0, 1'b1, 6'd7,  1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[20] = '{1'b1, 2'd0, 1'b1, 6'd7,  1'b1, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[21] = '{1'b1, 2'd0, 1'b0, 6'd7,  1'b0, 1'b1, 7'h00, 12'h1C2, 1'b1, 1'b0};
      vecs[22] = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b1, 7'h01, 12'h000, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};
      // 1-cycle record pulse -> lone marker at idx 0 of song 3
      vecs[24] = '{1'b1, 2'd3, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[25] = '{1'b0, 2'd3, 1'b0, 6'd0,  1'b0, 1'b1, 7'h60, 12'h000, 1'b0, 1'b0};
      vecs[26] = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};
      // record drop together with a beat at dur=0 -> {8,1}, then marker
      vecs[27] = '{1'b1, 2'd1, 1'b1, 6'd8,  1'b0, 1'b0, 7'h00, 12'h000, 1'b1, 1'b0};
      vecs[28] = '{1'b0, 2'd1, 1'b1, 6'd8,  1'b1, 1'b1, 7'h20, 12'h201, 1'b0, 1'b0};
      vecs[29] = '{1'b0, 2'd1, 1'b1, 6'd8,  1'b0, 1'b1, 7'h21, 12'h000, 1'b0, 1'b0};
      vecs[30] = '{1'b0, 2'd0, 1'b0, 6'd0,  1'b0, 1'b0, 7'h00, 12'h000, 1'b0, 1'b0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset.wr_en", 32'(wr_en), 0);
      check("reset.wr_addr", 32'(wr_addr), 0);
      check("reset.wr_data", 32'(wr_data), 0);
      check("reset.recording", 32'(recording), 0);
      check("reset.full", 32'(full), 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // Table-driven vectors
      for (int i = 0; i < 31; i++) begin
         cyc(vecs[i].rec, vecs[i].sng, vecs[i].kv, vecs[i].kn, vecs[i].bt);
         check($sformatf("vec%0d.wr_en", i), 32'(wr_en), 32'(vecs[i].e_wr));
         if (vecs[i].e_wr) begin
            check($sformatf("vec%0d.wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d.wr_data", i), 32'(wr_data), 32'(vecs[i].e_data));
         end
         check($sformatf("vec%0d.recording", i), 32'(recording), 32'(vecs[i].e_rec));
         check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].e_full));
      end

      // 2: key 9 held for 70 beats -> {9,63}, {9,7}, marker
      log_q.delete();
      cyc(1'b1, 2'd0, 1'b1, 6'd9, 1'b0);
      for (int b = 0; b < 70; b++) begin
         cyc(1'b1, 2'd0, 1'b1, 6'd9, 1'b1);
         cyc(1'b1, 2'd0, 1'b1, 6'd9, 1'b0);
      end
      repeat (3) cyc(1'b0, 2'd0, 1'b1, 6'd9, 1'b0);
      check("long.count", log_q.size(), 3);
      check_wr("long", 0, 7'h00, {6'd9, 6'd63});
      check_wr("long", 1, 7'h01, {6'd9, 6'd7});
      check_wr("long", 2, 7'h02, 12'h000);

      // 5: 31 one-beat notes into song 2 -> slots 0..30, marker at 31, FULL
      log_q.delete();
      cyc(1'b1, 2'd2, 1'b1, 6'd1, 1'b0);
      for (int i = 0; i < 31; i++) begin
         if (i > 0) cyc(1'b1, 2'd2, 1'b1, 6'(i + 1), 1'b0);
         cyc(1'b1, 2'd2, 1'b1, 6'(i + 1), 1'b1);
      end
      cyc(1'b1, 2'd2, 1'b0, 6'd0, 1'b0);
      check("fill.full_on_last_commit", 32'(full), 1);
      cyc(1'b1, 2'd2, 1'b0, 6'd0, 1'b0);
      for (int k = 0; k < 4; k++) cyc(1'b1, 2'd2, 1'b1, 6'(40 + k), 1'b1);
      check("fill.full_held", 32'(full), 1);
      check("fill.recording_low", 32'(recording), 0);
      check("fill.count", log_q.size(), 32);
      for (int i = 0; i < 31; i++) check_wr("fill", i, {2'd2, 5'(i)}, {6'(i + 1), 6'd1});
      check_wr("fill", 31, 7'h5F, 12'h000);
      cyc(1'b0, 2'd2, 1'b0, 6'd0, 1'b0);
      check("fill.full_cleared", 32'(full), 0);
      cyc(1'b0, 2'd0, 1'b0, 6'd0, 1'b0);
      check("fill.no_extra_writes", log_q.size(), 32);

      // 6: reset asserted right after a write, mid-TRACK
      cyc(1'b1, 2'd1, 1'b1, 6'd4, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 6'd4, 1'b1);
      cyc(1'b1, 2'd1, 1'b1, 6'd5, 1'b0);
      check("rst.write_before", 32'(wr_en), 1);
      log_q.delete();
      reset = 1'b0;
      #1;
      check("rst.async_wr_en", 32'(wr_en), 0);
      check("rst.async_recording", 32'(recording), 0);
      check("rst.async_addr", 32'(wr_addr), 0);
      check("rst.async_data", 32'(wr_data), 0);
      record = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.held_wr_en", 32'(wr_en), 0);
      reset = 1'b1;
      cyc(1'b0, 2'd1, 1'b1, 6'd4, 1'b0);
      check("rst.no_marker", log_q.size(), 0);
      cyc(1'b1, 2'd1, 1'b1, 6'd4, 1'b0);
      check("rst.restart_recording", 32'(recording), 1);
      cyc(1'b1, 2'd1, 1'b1, 6'd4, 1'b1);
      repeat (3) cyc(1'b0, 2'd1, 1'b1, 6'd4, 1'b0);
      check("rst.restart_count", log_q.size(), 2);
      check_wr("rst", 0, 7'h20, {6'd4, 6'd1});
      check_wr("rst", 1, 7'h21, 12'h000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
